// File: rtl/mem_rd_sched_pkg.sv
// Shared helpers for the mem_rd_sched read-port scheduler.
// Derives read latency and requester-ID width from the block parameters.
package mem_rd_sched_pkg;

    // Registered memory output adds one cycle on top of the array read.
    function automatic int rd_lat(input logic [63:0] dout_reg);
        return (dout_reg == "true") ? 2 : 1;
    endfunction

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a priority pointer.
// The pointer moves past the winner only when the grant is taken (advance).
module rr_arbiter
    import mem_rd_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = id_w(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;

    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_rd_sched.sv
// Read-port scheduler for a shared mem_1r1w_array: round-robin issue, latency tracking,
// one-hot tagged responses. MEM_RD_SCHED_BYPASS_EN forwards same-cycle write data.
module mem_rd_sched
    import mem_rd_sched_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter int          WIDTH_DATA = 8,
    parameter int          WIDTH_ADDR = 8,
    parameter logic [63:0] DOUT_REG   = "false"
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // Handshake: a read is accepted in any cycle where req_valid[i] && req_ready[i];
    // req_ready is combinational and never high for a requester that is not asking.
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [WIDTH_DATA-1:0]         rsp_data,
    output logic                          mem_ren,
    output logic [WIDTH_ADDR-1:0]         mem_raddr,
    input  logic [WIDTH_DATA-1:0]         mem_rdata,
    input  logic                          snp_wen,
    input  logic [WIDTH_ADDR-1:0]         snp_waddr,
    input  logic [WIDTH_DATA-1:0]         snp_din
);

    localparam int RD_LAT = rd_lat(DOUT_REG);
    localparam int IDW    = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    gnt;
    logic                  issue;
    logic [IDW-1:0]        gnt_id;
    logic [WIDTH_ADDR-1:0] gnt_addr;
    logic [RD_LAT-1:0]     pipe_v;
    logic [IDW-1:0]        pipe_id [RD_LAT];
    logic [WIDTH_DATA-1:0] rsp_raw;

    // Requests are masked during reset so no grant or memory read leaks out.
    assign arb_req = req_valid & {NUM_REQ{rst_n}};

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (issue),
        .gnt     (gnt)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;

    always_comb begin
        gnt_id   = '0;
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id   = IDW'(i);
                gnt_addr = req_addr[i*WIDTH_ADDR +: WIDTH_ADDR];
            end
        end
    end

    assign mem_ren   = issue;
    assign mem_raddr = gnt_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            for (int s = 1; s < RD_LAT; s++) pipe_v[s] <= pipe_v[s-1];
        end
        pipe_id[0] <= gnt_id;
        for (int s = 1; s < RD_LAT; s++) pipe_id[s] <= pipe_id[s-1];
    end

`ifdef MEM_RD_SCHED_BYPASS_EN
    logic                  collide;
    logic [RD_LAT-1:0]     pipe_c;
    logic [WIDTH_DATA-1:0] pipe_d [RD_LAT];

    // The array returns old data on a same-address write; carry the new data alongside.
    assign collide = issue && snp_wen && (snp_waddr == mem_raddr);

    always_ff @(posedge clk) begin
        pipe_c[0] <= collide;
        pipe_d[0] <= snp_din;
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_c[s] <= pipe_c[s-1];
            pipe_d[s] <= pipe_d[s-1];
        end
    end

    assign rsp_raw = pipe_c[RD_LAT-1] ? pipe_d[RD_LAT-1] : mem_rdata;
`else
    logic unused_snp;
    assign unused_snp = ^{snp_wen, snp_waddr, snp_din};
    assign rsp_raw    = mem_rdata;
`endif

    assign rsp_valid = pipe_v[RD_LAT-1] ? (NUM_REQ'(1) << pipe_id[RD_LAT-1]) : '0;
    assign rsp_data  = pipe_v[RD_LAT-1] ? rsp_raw : '0;

endmodule
